// File: rtl/bin_bcd_scan.sv
// bin_bcd_scan: 8-bit binary to 3-digit BCD converter (shift-and-add-3)
// with a free-running multiplexed 7-segment digit scanner.
//
// Handshake: start is a request sampled only while the FSM is IDLE
// (busy=0). A request seen while busy=1 is dropped, never queued. Each
// accepted request produces exactly one done pulse, registered in the
// cycle after the DONE state, and bcd changes only on that pulse.
module bin_bcd_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [3:0]  digit,
  output logic [2:0]  an,
  output logic [1:0]  dbg_state
);

  // ------------------------------------------------------------------
  // Converter FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Eight shift iterations, one per input bit.
  localparam logic [3:0] LAST_ITER = 4'd7;

  state_t      state;
  state_t      state_next;
  logic [7:0]  shift_reg;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [3:0]  iter;
  logic        accept;

  // A request is only honoured from IDLE; everywhere else it is ignored.
  assign accept = (state == S_IDLE) && start;

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the busy flag.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (iter == LAST_ITER) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // ------------------------------------------------------------------
  // Double-dabble datapath
  // ------------------------------------------------------------------

  // Add 3 to every scratch nibble that is 5 or more, ahead of the shift,
  // so the doubling carries correctly into the next decimal digit.
  always_comb begin
    scratch_adj = scratch;
    for (int n = 0; n < 3; n++) begin
      if (scratch[4*n +: 4] >= 4'd5) begin
        scratch_adj[4*n +: 4] = scratch[4*n +: 4] + 4'd3;
      end
    end
  end

  // Capture on accept, shift while converting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= 8'd0;
      scratch   <= 12'd0;
      iter      <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift_reg <= bin;
            scratch   <= 12'd0;
            iter      <= 4'd0;
          end
        end
        S_SHIFT: begin
          {scratch, shift_reg} <= {scratch_adj[10:0], shift_reg, 1'b0};
          iter                 <= iter + 4'd1;
        end
        default: begin
          iter <= iter;
        end
      endcase
    end
  end

  // Result register and done pulse: updated only while leaving DONE, so
  // bcd holds its old value for the whole conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd  <= 12'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_DONE) begin
        bcd  <= scratch;
        done <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Display scanner (free-running, independent of the converter)
  // ------------------------------------------------------------------
  localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] prescale;
  logic [1:0]  idx;
  logic        pre_wrap;

  assign pre_wrap = (prescale == PRE_MAX);

  // Prescaler 0..SCAN_DIV-1 and digit index 0 -> 1 -> 2 -> 0 on each wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= 16'd0;
      idx      <= 2'd0;
    end else begin
      if (pre_wrap) begin
        prescale <= 16'd0;
        idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        prescale <= prescale + 16'd1;
      end
    end
  end

  // Digit mux straight from registered bcd, so a new result shows at once.
  always_comb begin
    digit = bcd[3:0];
    case (idx)
      2'd1:    digit = bcd[7:4];
      2'd2:    digit = bcd[11:8];
      default: digit = bcd[3:0];
    endcase
  end

  logic hund_zero;
  logic tens_zero;

  assign hund_zero = (bcd[11:8] == 4'd0);
  assign tens_zero = (bcd[7:4] == 4'd0);

  // Digit enable: one-hot of the index, with optional leading-zero
  // blanking. The ones position is always lit; digit keeps showing the
  // nibble even when its enable is blanked.
  always_comb begin
    an = 3'b001;
    case (idx)
      2'd1: begin
        an = 3'b010;
        if (BLANK && hund_zero && tens_zero) begin
          an = 3'b000;
        end
      end
      2'd2: begin
        an = 3'b100;
        if (BLANK && hund_zero) begin
          an = 3'b000;
        end
      end
      default: begin
        an = 3'b001;
      end
    endcase
  end

endmodule
